mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported, synchronous 16-bit memory between the instruction-fetch requester and the load/store requester of the MIPS16 core.
- Each access is registered, and the memory returns read data one cycle after the access cycle.
- Data accesses have fixed priority over fetch. A bounded-streak counter prevents fetch starvation.
- Sits between the core's IF/MEM stages and the unified memory. Requesters use `busy` and the ack handshake to stall.

Parameters:
- AW, 16, address width in bits; passed to memory unchanged.
- DW, 16, data width in bits.
- MAX_DSTREAK, 3, maximum consecutive data grants while if_req is pending before fetch is forced; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  AW  fetch address; stable while if_req
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DW  fetched word; 0 when if_ack low
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1=store, 0=load; stable while d_req
- d_addr  in  AW  data address; stable while d_req
- d_wdata  in  DW  store data; stable while d_req
- d_ack  out  1  one-cycle pulse; access complete
- d_rdata  out  DW  load data; 0 when d_ack low or on a store ack
- mem_en  out  1  memory access enable (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  AW  memory address (registered)
- mem_wdata  out  DW  memory write data (registered)
- mem_rdata  in  DW  memory read data; valid the cycle after mem_en && !mem_we
- busy  out  1  high in ACCESS and RESP states

Behaviour:
- States: IDLE, ACCESS, RESP. An owner register (OWN_I / OWN_D) records the current grant.
- Reset: state=IDLE, owner=OWN_I, streak=0, and every output is 0.
- Reset mid-operation:
  - The access in flight is abandoned and no ack is issued.
  - A write already presented on mem_* in the reset cycle still commits at that edge.
  - Requesters must reissue after reset.
- Arbitration is performed in IDLE, and in RESP for the non-owner only:
  - d_req && (streak<MAX_DSTREAK || !if_req) -> grant D.
  - Otherwise if_req -> grant I.
  - Otherwise no grant.
- On a grant at edge N:
  - mem_en=1; mem_we=d_we for D and 0 for I.
  - mem_addr and mem_wdata are latched from the winner (mem_wdata=0 for I).
  - State goes to ACCESS.
- ACCESS, one cycle: mem_* hold their values, the memory samples at the next edge, then state goes to RESP and mem_en/mem_we clear.
- RESP, one cycle:
  - The owner's ack is 1. For a read, the owner's rdata = mem_rdata.
  - If the non-owner requests, it is granted directly (RESP->ACCESS). Otherwise state goes to IDLE.
- Latency: request at cycle N -> ack at cycle N+2. Sustained throughput is one access per 2 cycles with alternating owners, or per 3 cycles for the same owner.
- Streak counter:
  - Increments on each D grant while if_req=1, saturating at MAX_DSTREAK.
  - Clears on any I grant, or at any arbitration point where if_req=0.
- Simultaneous requests in IDLE with streak=0: D wins, then I follows from RESP.
- Protocol violation (req dropped before ack): the access completes and the ack is still pulsed; no error is flagged.
- A requester never sees two acks for one request. The ack is never asserted outside RESP.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - owner enum {OWN_I, OWN_D};
  - streak width localparam = $clog2(MAX_DSTREAK+1).
- One sub-module: mem_arb_streak_ctr, the saturating streak counter with inc/clr/at_max.
- FSM and datapath muxing stay in the top module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0004, memory word 0x2A11 -> mem_en=1 at cycle 1, if_ack=1 at cycle 2 with if_rdata=0x2A11; d_ack stays 0.
- Store then load:
  - Store with d_we=1, d_addr=0x0010, d_wdata=0xBEEF -> d_ack at cycle 2 with d_rdata=0.
  - Load of 0x0010 -> d_ack 3 cycles later with d_rdata=0xBEEF.
- Simultaneous if_req and d_req (load from 0x0020 = 0x1234; fetch from 0x0000 = 0x8C01) -> d_ack at cycle 2 with 0x1234; fetch granted from RESP; if_ack at cycle 4 with 0x8C01.
- Starvation, MAX_DSTREAK=3: d_req re-asserted immediately after each ack, if_req held -> exactly 3 d_acks, then if_ack, then data resumes.
- Reset asserted in the ACCESS cycle of a store to 0x0030=0x5555 -> next cycle all outputs are 0 with no ack; a subsequent load of 0x0030 returns 0x5555.
- Idle: no requests for 10 cycles -> mem_en=0, busy=0, acks 0, streak=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ACCESS, RESP)
//   owner_e     : which requester holds the current grant
//   streak_width: bits needed to count data grants up to a given maximum
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  localparam int unsigned MAX_DSTREAK_DFLT = 3;

  // Width of the streak counter: $clog2(max_streak + 1).
  function automatic int unsigned streak_width(input int unsigned max_streak);
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// Saturating counter of consecutive data grants made while a fetch is waiting.
// Ports:
//   clk_i     clock
//   reset_i   synchronous, active-high reset (count -> 0)
//   inc_i     count one more data grant (ignored once saturated)
//   clr_i     clear the count; wins over inc_i
//   at_max_o  count has reached MaxVal, fetch must be served next
module mem_arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MaxVal = MAX_DSTREAK_DFLT,
  parameter int unsigned Width  = streak_width(MaxVal)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  logic [Width-1:0] count_q, count_d;

  assign at_max_o = (count_q == Width'(MaxVal));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !at_max_o) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch (I)
// and load/store (D). Each access takes ACCESS (mem_* presented) then RESP
// (ack pulsed, read data passed through from mem_rdata). D has priority,
// bounded by a streak counter so a waiting fetch is served after at most
// MAX_DSTREAK consecutive data grants.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   if_req/if_addr             fetch request, held until if_ack
//   if_ack/if_rdata            fetch completion pulse and word (0 otherwise)
//   d_req/d_we/d_addr/d_wdata  data request, held until d_ack
//   d_ack/d_rdata              data completion pulse, load data (0 otherwise)
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory access
//   mem_rdata                  memory read data, valid cycle after a read
//   busy                       high in ACCESS and RESP
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 16,
  parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DFLT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned SW = streak_width(MAX_DSTREAK);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          acc_we_q, acc_we_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic win_d, win_i;
  logic grant_d, grant_i;
  logic arb_point;
  logic streak_inc, streak_clr, streak_at_max;

  mem_arb_streak_ctr #(
    .MaxVal(MAX_DSTREAK),
    .Width (SW)
  ) u_streak (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (streak_inc),
    .clr_i   (streak_clr),
    .at_max_o(streak_at_max)
  );

  // Raw arbitration result from the current requests. D loses only when a
  // fetch is waiting and the data streak has saturated.
  assign win_d = d_req && (!streak_at_max || !if_req);
  assign win_i = !win_d && if_req;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    acc_we_d    = acc_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    arb_point   = 1'b0;

    unique case (state_q)
      IDLE: begin
        arb_point = 1'b1;
        grant_d   = win_d;
        grant_i   = win_i;
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        // The owner is being acked this cycle, so only a win by the other
        // requester turns into a back-to-back grant.
        arb_point = 1'b1;
        grant_d   = win_d && (owner_q == OWN_I);
        grant_i   = win_i && (owner_q == OWN_D);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_d) begin
      state_d     = ACCESS;
      owner_d     = OWN_D;
      acc_we_d    = d_we;
      mem_en_d    = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
    end else if (grant_i) begin
      state_d     = ACCESS;
      owner_d     = OWN_I;
      acc_we_d    = 1'b0;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
    end

    // In ACCESS the registered mem_* must stay up for the memory to sample.
    if (state_q == ACCESS) begin
      mem_en_d = mem_en_q;
      mem_we_d = mem_we_q;
    end
  end

  // Streak only grows while a fetch is actually waiting.
  assign streak_inc = grant_d && if_req;
  assign streak_clr = arb_point && (grant_i || !if_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      acc_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      acc_we_q    <= acc_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // ACCESS lasts one cycle, so mem_en/mem_we drop when entering RESP.
  assign mem_en    = mem_en_q && (state_q == ACCESS);
  assign mem_we    = mem_we_q && (state_q == ACCESS);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign busy     = (state_q != IDLE);
  assign if_ack   = (state_q == RESP) && (owner_q == OWN_I);
  assign d_ack    = (state_q == RESP) && (owner_q == OWN_D);
  assign if_rdata = if_ack ? mem_rdata : '0;
  assign d_rdata  = (d_ack && !acc_we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        tb_init;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(16),
    .DW(16),
    .MAX_DSTREAK(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  // Synchronous single-port memory: read data appears the cycle after access.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= '0;
      mem[16'h0000] <= 16'h8C01;
      mem[16'h0004] <= 16'h2A11;
      mem[16'h0020] <= 16'h1234;
      mem_rdata     <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // {mem_en, mem_we, busy, if_ack, d_ack, mem_addr, mem_wdata, if_rdata, d_rdata}
  logic [68:0] act;
  assign act = {mem_en, mem_we, busy, if_ack, d_ack, mem_addr, mem_wdata, if_rdata, d_rdata};

  typedef struct {
    logic        if_req;
    logic [15:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [68:0] exp;
  } vec_t;

  vec_t vecs [17];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic ir, input logic [15:0] ia, input logic dr,
                              input logic dw, input logic [15:0] da, input logic [15:0] dwd,
                              input logic [4:0] fl, input logic [15:0] ma,
                              input logic [15:0] mw, input logic [15:0] ird,
                              input logic [15:0] drd);
    vec_t v;
    v.if_req  = ir;
    v.if_addr = ia;
    v.d_req   = dr;
    v.d_we    = dw;
    v.d_addr  = da;
    v.d_wdata = dwd;
    v.exp     = {fl, ma, mw, ird, drd};
    return v;
  endfunction

  task automatic check(input string name, input logic [68:0] got, input logic [68:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic set_in(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                        input logic [15:0] da, input logic [15:0] dwd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [12:0] exp_ia;
  logic [12:0] exp_da;

  initial begin
    // flags = {mem_en, mem_we, busy, if_ack, d_ack}
    // Fetch only
    vecs[0]  = mk(1, 16'h0004, 0, 0, 16'h0000, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    vecs[1]  = mk(1, 16'h0004, 0, 0, 16'h0000, 16'h0000, 5'b10100, 16'h0004, 16'h0000, 16'h0000, 16'h0000);
    vecs[2]  = mk(1, 16'h0004, 0, 0, 16'h0000, 16'h0000, 5'b00110, 16'h0004, 16'h0000, 16'h2A11, 16'h0000);
    vecs[3]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 5'b00000, 16'h0004, 16'h0000, 16'h0000, 16'h0000);
    // Store 0xBEEF to 0x0010, then load it back
    vecs[4]  = mk(0, 16'h0000, 1, 1, 16'h0010, 16'hBEEF, 5'b00000, 16'h0004, 16'h0000, 16'h0000, 16'h0000);
    vecs[5]  = mk(0, 16'h0000, 1, 1, 16'h0010, 16'hBEEF, 5'b11100, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000);
    vecs[6]  = mk(0, 16'h0000, 1, 1, 16'h0010, 16'hBEEF, 5'b00101, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000);
    vecs[7]  = mk(0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 5'b00000, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000);
    vecs[8]  = mk(0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 5'b10100, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
    vecs[9]  = mk(0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 5'b00101, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF);
    vecs[10] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 5'b00000, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
    // Simultaneous: D first, I granted straight from D's RESP
    vecs[11] = mk(1, 16'h0000, 1, 0, 16'h0020, 16'h0000, 5'b00000, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
    vecs[12] = mk(1, 16'h0000, 1, 0, 16'h0020, 16'h0000, 5'b10100, 16'h0020, 16'h0000, 16'h0000, 16'h0000);
    vecs[13] = mk(1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 5'b00101, 16'h0020, 16'h0000, 16'h0000, 16'h1234);
    vecs[14] = mk(1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 5'b10100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    vecs[15] = mk(1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 5'b00110, 16'h0000, 16'h0000, 16'h8C01, 16'h0000);
    vecs[16] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    reset   = 1'b1;
    tb_init = 1'b1;
    set_in(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", act, 69'd0);
    tick();
    reset   = 1'b0;
    tb_init = 1'b0;

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req, vecs[i].d_we,
             vecs[i].d_addr, vecs[i].d_wdata);
      @(negedge clk);
      check($sformatf("vec%0d", i), act, vecs[i].exp);
      tick();
    end

    // Starvation: fetch held, loads back to back. Three d_acks, then if_ack,
    // then data resumes straight from the fetch RESP.
    exp_ia = 13'b0010000000000;
    exp_da = 13'b1000100100100;
    for (int s = 0; s < 13; s++) begin
      set_in(1, 16'h0000, 1, 0, 16'h0020, 16'h0000);
      @(negedge clk);
      check($sformatf("starve%0d", s), {67'd0, if_ack, d_ack}, {67'd0, exp_ia[s], exp_da[s]});
      tick();
    end
    set_in(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    tick();
    tick();

    // Reset during ACCESS of a store: the presented write still lands.
    set_in(0, 16'h0000, 1, 1, 16'h0030, 16'h5555);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rst_access", act, {5'b11100, 16'h0030, 16'h5555, 16'h0000, 16'h0000});
    tick();
    reset = 1'b0;
    set_in(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("rst_after", act, 69'd0);
    tick();
    @(negedge clk);
    check("rst_no_ack", {64'd0, mem_en, mem_we, busy, if_ack, d_ack}, 69'd0);
    tick();
    set_in(0, 16'h0000, 1, 0, 16'h0030, 16'h0000);
    tick();
    tick();
    @(negedge clk);
    check("rst_load", act, {5'b00101, 16'h0030, 16'h0000, 16'h0000, 16'h5555});
    tick();
    set_in(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    tick();

    // Idle: nothing moves.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("idle%0d", k), {64'd0, mem_en, mem_we, busy, if_ack, d_ack}, 69'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
